alu_seq: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 36 +++
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_seq_iter.sv | 98 +++++++++
 rtl/alu_seq.sv | 201 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the registered sequential ALU: opcodes, FSM states,
// iteration-unit operation codes and the add/sub overflow helper.
package alu_seq_pkg;

    localparam logic [3:0] OP_PASSA = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_PASSB = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_NOTA  = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_SHR   = 4'd9;
    localparam logic [3:0] OP_ASR   = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        IT_SHL = 2'd0,
        IT_SHR = 2'd1,
        IT_ASR = 2'd2,
        IT_MUL = 2'd3
    } iter_op_t;

    // Signed overflow of a + b_eff: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the register-file read side, the ALU and write-back.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A_in;
    logic [WIDTH-1:0] B_in;
    logic             c_in;
    logic [3:0]       select;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUres;
    logic             Z;
    logic             C;
    logic             N;
    logic             V;
    logic             err;

    modport master (
        output in_valid, A_in, B_in, c_in, select, out_ready,
        input  in_ready, out_valid, ALUres, Z, C, N, V, err
    );

    modport slave (
        input  in_valid, A_in, B_in, c_in, select, out_ready,
        output in_ready, out_valid, ALUres, Z, C, N, V, err
    );
endinterface

// File: rtl/alu_seq_iter.sv
// Iteration engine for multi-cycle ops: one-bit-per-cycle shifts and a shift-add
// multiplier. done marks the edge that performs the last step; result/carry are that step's output.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  iter_op_t           op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               carry
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    iter_op_t             op_r;
    logic                 busy_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [WIDTH-1:0]     acc_r;
    logic [WIDTH-1:0]     mplier_r;
    logic [2*WIDTH-1:0]   mcand_r;
    logic [2*WIDTH-1:0]   prod_r;
    logic [WIDTH-1:0]     acc_next_s;
    logic [2*WIDTH-1:0]   prod_next_s;
    logic                 out_bit_s;

    // One iteration step of the latched operation
    always_comb begin
        acc_next_s  = acc_r;
        prod_next_s = prod_r;
        out_bit_s   = 1'b0;
        case (op_r)
            IT_SHL: begin
                acc_next_s = {acc_r[WIDTH-2:0], 1'b0};
                out_bit_s  = acc_r[WIDTH-1];
            end
            IT_SHR: begin
                acc_next_s = {1'b0, acc_r[WIDTH-1:1]};
                out_bit_s  = acc_r[0];
            end
            IT_ASR: begin
                acc_next_s = {acc_r[WIDTH-1], acc_r[WIDTH-1:1]};
                out_bit_s  = acc_r[0];
            end
            IT_MUL: begin
                if (mplier_r[0]) begin
                    prod_next_s = prod_r + mcand_r;
                end else begin
                    prod_next_s = prod_r;
                end
            end
            default: begin
                acc_next_s = acc_r;
            end
        endcase
    end

    assign done   = busy_r && (cnt_r == CNT_W'(1));
    assign result = (op_r == IT_MUL) ? prod_next_s[WIDTH-1:0] : acc_next_s;
    assign carry  = (op_r == IT_MUL) ? (|prod_next_s[2*WIDTH-1:WIDTH]) : out_bit_s;

    // Operand latch on start, then step and count down until done
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r     <= IT_SHL;
            busy_r   <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            prod_r   <= {(2*WIDTH){1'b0}};
        end else if (start) begin
            op_r     <= op;
            busy_r   <= 1'b1;
            cnt_r    <= (op == IT_MUL) ? CNT_W'(WIDTH) : CNT_W'(shamt);
            acc_r    <= a;
            mplier_r <= b;
            mcand_r  <= {{WIDTH{1'b0}}, a};
            prod_r   <= {(2*WIDTH){1'b0}};
        end else if (busy_r) begin
            acc_r    <= acc_next_s;
            prod_r   <= prod_next_s;
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            cnt_r    <= cnt_r - CNT_W'(1);
            busy_r   <= !done;
        end else begin
            busy_r   <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with Z/C/N/V flags and valid/ready on both sides. Single-cycle ops
// are computed here; non-zero shifts and MUL are handed to alu_seq_iter.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);

    state_t             state_r;
    state_t             state_next_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               iter_start_s;
    logic               iter_done_s;
    logic [SHAMT_W-1:0] shamt_s;
    logic               is_shift_s;
    logic               is_mul_s;
    logic               multi_s;
    iter_op_t           iter_op_s;
    logic [WIDTH-1:0]   b_eff_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH-1:0]   res_s;
    logic               carry_s;
    logic               ovf_s;
    logic               err_s;
    logic [WIDTH-1:0]   iter_res_s;
    logic               iter_carry_s;
    logic [WIDTH-1:0]   alu_res_r;
    logic               z_r, c_r, n_r, v_r, err_r, out_valid_r;

    // Classify the presented opcode; zero-amount shifts stay single-cycle
    always_comb begin
        shamt_s    = bus.B_in[SHAMT_W-1:0];
        is_mul_s   = (bus.select == OP_MUL);
        iter_op_s  = IT_MUL;
        is_shift_s = 1'b0;
        case (bus.select)
            OP_SHL: begin
                iter_op_s  = IT_SHL;
                is_shift_s = 1'b1;
            end
            OP_SHR: begin
                iter_op_s  = IT_SHR;
                is_shift_s = 1'b1;
            end
            OP_ASR: begin
                iter_op_s  = IT_ASR;
                is_shift_s = 1'b1;
            end
            default: begin
                iter_op_s  = IT_MUL;
                is_shift_s = 1'b0;
            end
        endcase
        multi_s = is_mul_s || (is_shift_s && (shamt_s != {SHAMT_W{1'b0}}));
    end

    // Second adder operand: PASSA is A + 0 + c_in, SUB uses ~B
    always_comb begin
        case (bus.select)
            OP_ADD:  b_eff_s = bus.B_in;
            OP_SUB:  b_eff_s = ~bus.B_in;
            default: b_eff_s = {WIDTH{1'b0}};
        endcase
    end

    assign sum_s = {1'b0, bus.A_in} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, bus.c_in};

    // Single-cycle result, carry, overflow and illegal-opcode detection
    always_comb begin
        res_s   = {WIDTH{1'b0}};
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        err_s   = 1'b0;
        case (bus.select)
            OP_PASSA: begin
                res_s   = sum_s[WIDTH-1:0];
                carry_s = sum_s[WIDTH];
            end
            OP_ADD, OP_SUB: begin
                res_s   = sum_s[WIDTH-1:0];
                carry_s = sum_s[WIDTH];
                ovf_s   = add_ovf(bus.A_in[WIDTH-1], b_eff_s[WIDTH-1], sum_s[WIDTH-1]);
            end
            OP_PASSB:               res_s = bus.B_in;
            OP_AND:                 res_s = bus.A_in & bus.B_in;
            OP_OR:                  res_s = bus.A_in | bus.B_in;
            OP_XOR:                 res_s = bus.A_in ^ bus.B_in;
            OP_NOTA:                res_s = ~bus.A_in;
            OP_SHL, OP_SHR, OP_ASR: res_s = bus.A_in;
            OP_MUL:                 res_s = {WIDTH{1'b0}};
            default:                err_s = 1'b1;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && multi_s) begin
                    state_next_s = is_mul_s ? MUL : SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT, MUL: begin
                if (iter_done_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs: ready only when idle and the output slot is free or draining
    always_comb begin
        if (state_r == IDLE) begin
            in_ready_s = (!out_valid_r || bus.out_ready) && !rst;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s     = bus.in_valid && in_ready_s;
        iter_start_s = accept_s && multi_s;
    end

    alu_seq_iter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (iter_start_s),
        .op     (iter_op_s),
        .a      (bus.A_in),
        .b      (bus.B_in),
        .shamt  (shamt_s),
        .done   (iter_done_s),
        .result (iter_res_s),
        .carry  (iter_carry_s)
    );

    // Output register: load on single-cycle accept or iteration done, else drain
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_res_r   <= {WIDTH{1'b0}};
            z_r         <= 1'b0;
            c_r         <= 1'b0;
            n_r         <= 1'b0;
            v_r         <= 1'b0;
            err_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (accept_s && !multi_s) begin
            alu_res_r   <= res_s;
            z_r         <= (res_s == {WIDTH{1'b0}});
            c_r         <= carry_s;
            n_r         <= res_s[WIDTH-1];
            v_r         <= ovf_s;
            err_r       <= err_s;
            out_valid_r <= 1'b1;
        end else if (iter_done_s) begin
            alu_res_r   <= iter_res_s;
            z_r         <= (iter_res_s == {WIDTH{1'b0}});
            c_r         <= iter_carry_s;
            n_r         <= iter_res_s[WIDTH-1];
            v_r         <= 1'b0;
            err_r       <= 1'b0;
            out_valid_r <= 1'b1;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.ALUres    = alu_res_r;
    assign bus.Z         = z_r;
    assign bus.C         = c_r;
    assign bus.N         = n_r;
    assign bus.V         = v_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8; flags compared as {Z,C,N,V,err}.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    alu_seq_if #(.WIDTH(8)) bus();

    alu_seq #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic ci);
        bus.select   = op;
        bus.A_in     = a;
        bus.B_in     = b;
        bus.c_in     = ci;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Presents junk while busy; counts cycles until out_valid and busy cycles with in_ready high.
    task automatic wait_result(output int cyc, output int rdy_hi);
        cyc    = 0;
        rdy_hi = 0;
        bus.in_valid = 1'b1;
        bus.select   = 4'd1;
        bus.A_in     = 8'h5A;
        bus.B_in     = 8'hA5;
        while (!bus.out_valid && cyc < 40) begin
            if (bus.in_ready) rdy_hi++;
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.ALUres !== 8'h00) begin bad++; $display("FAIL rst_res got=%h want=00", bus.ALUres); end
        total++; if ({bus.Z, bus.C, bus.N, bus.V, bus.err} !== 5'b00000) begin bad++; $display("FAIL rst_flags got=%b want=00000", {bus.Z, bus.C, bus.N, bus.V, bus.err}); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_inready got=%b want=0", bus.in_ready); end
        rst = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_inready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_arith();
        issue(4'd1, 8'hFF, 8'h01, 1'b0);
        total++; if (bus.out_valid !== 1'b1 || bus.ALUres !== 8'h00) begin bad++; $display("FAIL add_res got=%b/%h want=1/00", bus.out_valid, bus.ALUres); end
        total++; if ({bus.Z, bus.C, bus.N, bus.V, bus.err} !== 5'b11000) begin bad++; $display("FAIL add_flags got=%b want=11000", {bus.Z, bus.C, bus.N, bus.V, bus.err}); end
        tick();
        total++; if (bus.out_valid !== 1'b0 || bus.ALUres !== 8'h00) begin bad++; $display("FAIL add_release got=%b/%h want=0/00", bus.out_valid, bus.ALUres); end
        issue(4'd2, 8'h80, 8'h01, 1'b1);
        total++; if (bus.ALUres !== 8'h7F) begin bad++; $display("FAIL sub_res got=%h want=7f", bus.ALUres); end
        total++; if ({bus.Z, bus.C, bus.N, bus.V, bus.err} !== 5'b01010) begin bad++; $display("FAIL sub_flags got=%b want=01010", {bus.Z, bus.C, bus.N, bus.V, bus.err}); end
        issue(4'd0, 8'hFF, 8'h33, 1'b1);
        total++; if (bus.ALUres !== 8'h00 || {bus.Z, bus.C, bus.N, bus.V, bus.err} !== 5'b11000) begin bad++; $display("FAIL passa got=%h/%b want=00/11000", bus.ALUres, {bus.Z, bus.C, bus.N, bus.V, bus.err}); end
        issue(4'd3, 8'h01, 8'h80, 1'b0);
        total++; if (bus.ALUres !== 8'h80 || {bus.Z, bus.C, bus.N, bus.V, bus.err} !== 5'b00100) begin bad++; $display("FAIL passb got=%h/%b want=80/00100", bus.ALUres, {bus.Z, bus.C, bus.N, bus.V, bus.err}); end
    endtask

    task automatic test_shift();
        int cyc;
        int rdy_hi;
        issue(4'd8, 8'h81, 8'h03, 1'b0);
        wait_result(cyc, rdy_hi);
        total++; if (cyc != 3) begin bad++; $display("FAIL shl_latency got=%0d want=3", cyc); end
        total++; if (rdy_hi != 0) begin bad++; $display("FAIL shl_busy_ready got=%0d want=0", rdy_hi); end
        total++; if (bus.ALUres !== 8'h08 || {bus.Z, bus.C, bus.N, bus.V, bus.err} !== 5'b00000) begin bad++; $display("FAIL shl_res got=%h/%b want=08/00000", bus.ALUres, {bus.Z, bus.C, bus.N, bus.V, bus.err}); end
        issue(4'd10, 8'h80, 8'h02, 1'b0);
        wait_result(cyc, rdy_hi);
        total++; if (cyc != 2) begin bad++; $display("FAIL asr_latency got=%0d want=2", cyc); end
        total++; if (bus.ALUres !== 8'hE0 || {bus.Z, bus.C, bus.N, bus.V, bus.err} !== 5'b00100) begin bad++; $display("FAIL asr_res got=%h/%b want=e0/00100", bus.ALUres, {bus.Z, bus.C, bus.N, bus.V, bus.err}); end
        issue(4'd9, 8'h81, 8'h01, 1'b0);
        wait_result(cyc, rdy_hi);
        total++; if (cyc != 1 || bus.ALUres !== 8'h40 || {bus.Z, bus.C, bus.N, bus.V, bus.err} !== 5'b01000) begin bad++; $display("FAIL shr_res got=%0d/%h/%b want=1/40/01000", cyc, bus.ALUres, {bus.Z, bus.C, bus.N, bus.V, bus.err}); end
        issue(4'd8, 8'h81, 8'h08, 1'b0);
        total++; if (bus.out_valid !== 1'b1 || bus.ALUres !== 8'h81 || {bus.Z, bus.C, bus.N, bus.V, bus.err} !== 5'b00100) begin bad++; $display("FAIL shl_k0 got=%b/%h/%b want=1/81/00100", bus.out_valid, bus.ALUres, {bus.Z, bus.C, bus.N, bus.V, bus.err}); end
    endtask

    task automatic test_mul();
        int cyc;
        int rdy_hi;
        issue(4'd11, 8'h0F, 8'h11, 1'b0);
        wait_result(cyc, rdy_hi);
        total++; if (cyc != 8 || rdy_hi != 0) begin bad++; $display("FAIL mul_latency got=%0d/%0d want=8/0", cyc, rdy_hi); end
        total++; if (bus.ALUres !== 8'hFF || {bus.Z, bus.C, bus.N, bus.V, bus.err} !== 5'b00100) begin bad++; $display("FAIL mul_res got=%h/%b want=ff/00100", bus.ALUres, {bus.Z, bus.C, bus.N, bus.V, bus.err}); end
        issue(4'd11, 8'h10, 8'h10, 1'b0);
        wait_result(cyc, rdy_hi);
        total++; if (cyc != 8 || bus.ALUres !== 8'h00 || {bus.Z, bus.C, bus.N, bus.V, bus.err} !== 5'b11000) begin bad++; $display("FAIL mul_ovf got=%0d/%h/%b want=8/00/11000", cyc, bus.ALUres, {bus.Z, bus.C, bus.N, bus.V, bus.err}); end
    endtask

    task automatic test_illegal();
        issue(4'd13, 8'h12, 8'h34, 1'b1);
        total++; if (bus.out_valid !== 1'b1 || bus.ALUres !== 8'h00 || {bus.Z, bus.C, bus.N, bus.V, bus.err} !== 5'b10001) begin bad++; $display("FAIL illegal got=%b/%h/%b want=1/00/10001", bus.out_valid, bus.ALUres, {bus.Z, bus.C, bus.N, bus.V, bus.err}); end
        issue(4'd1, 8'h01, 8'h02, 1'b0);
        total++; if (bus.ALUres !== 8'h03 || {bus.Z, bus.C, bus.N, bus.V, bus.err} !== 5'b00000) begin bad++; $display("FAIL illegal_clear got=%h/%b want=03/00000", bus.ALUres, {bus.Z, bus.C, bus.N, bus.V, bus.err}); end
    endtask

    task automatic test_back_to_back();
        bus.select = 4'd5; bus.A_in = 8'h0F; bus.B_in = 8'hF0; bus.c_in = 1'b0; bus.in_valid = 1'b1;
        tick();
        total++; if (bus.ALUres !== 8'hFF || bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_first got=%h/%b want=ff/1", bus.ALUres, bus.in_ready); end
        bus.select = 4'd7; bus.A_in = 8'hFF;
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1 || bus.ALUres !== 8'h00 || {bus.Z, bus.C, bus.N, bus.V, bus.err} !== 5'b10000) begin bad++; $display("FAIL b2b_second got=%b/%h/%b want=1/00/10000", bus.out_valid, bus.ALUres, {bus.Z, bus.C, bus.N, bus.V, bus.err}); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        issue(4'd4, 8'hF0, 8'h3C, 1'b0);
        bus.select = 4'd6; bus.A_in = 8'hAA; bus.B_in = 8'h55; bus.c_in = 1'b0; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (bus.out_valid !== 1'b1 || bus.ALUres !== 8'h30 || {bus.Z, bus.C, bus.N, bus.V, bus.err} !== 5'b00000 || bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_%0d got=%b/%h/%b/%b want=1/30/00000/0", i, bus.out_valid, bus.ALUres, {bus.Z, bus.C, bus.N, bus.V, bus.err}, bus.in_ready);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b want=1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1 || bus.ALUres !== 8'hFF || {bus.Z, bus.C, bus.N, bus.V, bus.err} !== 5'b00100) begin bad++; $display("FAIL queued_xor got=%b/%h/%b want=1/ff/00100", bus.out_valid, bus.ALUres, {bus.Z, bus.C, bus.N, bus.V, bus.err}); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL xor_drain got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_reset_mid_mul();
        int seen;
        issue(4'd11, 8'h0F, 8'h11, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        total++; if (bus.out_valid !== 1'b0 || bus.ALUres !== 8'h00 || {bus.Z, bus.C, bus.N, bus.V, bus.err} !== 5'b00000) begin bad++; $display("FAIL midmul_rst got=%b/%h/%b want=0/00/00000", bus.out_valid, bus.ALUres, {bus.Z, bus.C, bus.N, bus.V, bus.err}); end
        rst = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midmul_ready got=%b want=1", bus.in_ready); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL midmul_stale got=%0d want=0", seen); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.A_in      = 8'h00;
        bus.B_in      = 8'h00;
        bus.c_in      = 1'b0;
        bus.select    = 4'd0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        test_reset();
        test_arith();
        test_shift();
        test_mul();
        test_illegal();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
